// File: rtl/mux_gate_seq_pkg.sv
// Shared types and the micro-op program table for the mux gate sequencer.
package mux_gate_seq_pkg;

  localparam int MAX_STEPS = 3;
  localparam int STEP_W    = 2;

  typedef enum logic [2:0] {
    OP_NOT_A = 3'd0,
    OP_AND   = 3'd1,
    OP_OR    = 3'd2,
    OP_XOR   = 3'd3,
    OP_XNOR  = 3'd4,
    OP_MAJ   = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    SRC_ZERO = 3'd0,
    SRC_ONE  = 3'd1,
    SRC_A    = 3'd2,
    SRC_B    = 3'd3,
    SRC_C    = 3'd4,
    SRC_T0   = 3'd5,
    SRC_T1   = 3'd6
  } src_e;

  typedef enum logic {
    DST_T0 = 1'b0,
    DST_T1 = 1'b1
  } dst_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    src_e sel_src;
    src_e d0_src;
    src_e d1_src;
    dst_e dst;
    logic last;
  } uop_t;

  // Codes 6 and 7 have no program.
  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

  // Argument order mirrors the table notation mux(d0, d1, sel).
  function automatic uop_t mk(input src_e d0, input src_e d1, input src_e sel,
                              input dst_e dst, input logic last);
    uop_t u;
    u.sel_src = sel;
    u.d0_src  = d0;
    u.d1_src  = d1;
    u.dst     = dst;
    u.last    = last;
    return u;
  endfunction

  // Program table: each op is a short sequence of 2:1 mux micro-ops.
  function automatic uop_t prog_lookup(input logic [2:0] op, input logic [STEP_W-1:0] step);
    uop_t u;
    u = mk(SRC_ZERO, SRC_ZERO, SRC_A, DST_T0, 1'b1);
    case (op_e'(op))
      OP_NOT_A: u = mk(SRC_ONE, SRC_ZERO, SRC_A, DST_T0, 1'b1);
      OP_AND:   u = mk(SRC_ZERO, SRC_B, SRC_A, DST_T0, 1'b1);
      OP_OR:    u = mk(SRC_B, SRC_ONE, SRC_A, DST_T0, 1'b1);
      OP_XOR:
        if (step == '0) u = mk(SRC_ONE, SRC_ZERO, SRC_B, DST_T0, 1'b0);
        else            u = mk(SRC_B, SRC_T0, SRC_A, DST_T0, 1'b1);
      OP_XNOR:
        if (step == '0) u = mk(SRC_ONE, SRC_ZERO, SRC_B, DST_T0, 1'b0);
        else            u = mk(SRC_T0, SRC_B, SRC_A, DST_T0, 1'b1);
      OP_MAJ:
        case (step)
          2'd0:    u = mk(SRC_ZERO, SRC_B, SRC_A, DST_T0, 1'b0);
          2'd1:    u = mk(SRC_B, SRC_ONE, SRC_A, DST_T1, 1'b0);
          default: u = mk(SRC_T0, SRC_T1, SRC_C, DST_T0, 1'b1);
        endcase
      default: u = mk(SRC_ZERO, SRC_ZERO, SRC_A, DST_T0, 1'b1);
    endcase
    return u;
  endfunction

endpackage

// File: rtl/mux.sv
// One-bit 2:1 mux cell; the only logic element that forms results.
module mux (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_gate_sequencer.sv
// Evaluates small logic ops by sequencing micro-ops through one shared
// WIDTH-bit 2:1 mux, with scratch registers t0/t1 holding partial results.
module mux_gate_sequencer
  import mux_gate_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [7:0]       done_count
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [2:0]          op_q, op_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, c_q, c_d;
  logic [WIDTH-1:0]    t0_q, t0_d, t1_q, t1_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                err_q, err_d;
  logic [7:0]          done_count_q, done_count_d;

  uop_t                uop;
  logic                legal;
  logic                exec_end;
  logic [WIDTH-1:0]    sel_v, d0_v, d1_v, mux_y;

  function automatic logic [WIDTH-1:0] src_val(input src_e s,
                                               input logic [WIDTH-1:0] va,
                                               input logic [WIDTH-1:0] vb,
                                               input logic [WIDTH-1:0] vc,
                                               input logic [WIDTH-1:0] vt0,
                                               input logic [WIDTH-1:0] vt1);
    case (s)
      SRC_ONE: return '1;
      SRC_A:   return va;
      SRC_B:   return vb;
      SRC_C:   return vc;
      SRC_T0:  return vt0;
      SRC_T1:  return vt1;
      default: return '0;
    endcase
  endfunction

  assign uop      = prog_lookup(op_q, step_q);
  assign legal    = op_legal(op_q);
  assign exec_end = uop.last || !legal;

  // Route the current micro-op's sources onto the shared mux inputs.
  always_comb begin
    sel_v = src_val(uop.sel_src, a_q, b_q, c_q, t0_q, t1_q);
    d0_v  = src_val(uop.d0_src,  a_q, b_q, c_q, t0_q, t1_q);
    d1_v  = src_val(uop.d1_src,  a_q, b_q, c_q, t0_q, t1_q);
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      mux u_mux (
        .sel (sel_v[gi]),
        .d0  (d0_v[gi]),
        .d1  (d1_v[gi]),
        .y   (mux_y[gi])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept in IDLE, run the program, hold until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_EXEC;
      ST_EXEC: if (exec_end) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Datapath next values: operand capture, scratch writes, result and count.
  always_comb begin
    step_d       = step_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    t0_d         = t0_q;
    t1_d         = t1_q;
    result_d     = result_q;
    err_d        = err_q;
    done_count_d = done_count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d   = op;
          a_d    = a;
          b_d    = b;
          c_d    = c;
          step_d = '0;
        end
      end
      ST_EXEC: begin
        step_d = step_q + STEP_W'(1);
        // Illegal ops spend one cycle here without touching the scratch regs.
        if (legal) begin
          if (uop.dst == DST_T0) t0_d = mux_y;
          else                   t1_d = mux_y;
        end
        if (exec_end) begin
          result_d = legal ? mux_y : '0;
          err_d    = !legal;
        end
      end
      ST_DONE: begin
        if (out_ready) done_count_d = done_count_q + 8'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q       <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      t0_q         <= '0;
      t1_q         <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      done_count_q <= '0;
    end else begin
      step_q       <= step_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      t0_q         <= t0_d;
      t1_q         <= t1_d;
      result_q     <= result_d;
      err_q        <= err_d;
      done_count_q <= done_count_d;
    end
  end

  assign result     = result_q;
  assign err        = err_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_mux_gate_sequencer.sv
// Scoreboard bench for mux_gate_sequencer: driver pushes expected results,
// a negedge monitor pops and compares when out_valid appears.
module tb_mux_gate_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, err;
  logic [2:0] op;
  logic [7:0] a, b, c, result, done_count;

  always #5 clk = ~clk;

  mux_gate_sequencer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .c          (c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .err        (err),
    .done_count (done_count)
  );

  typedef struct {
    logic [7:0] res;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   accepts  = 0;
  int   acc0     = 0;
  int   edone    = 0;
  bit   busy_out = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Monitor: timestamps accepts, checks each delivered result against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_out = 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          acc_cyc = cyc + 1;
          accepts++;
        end
        if (out_valid) begin
          if (!busy_out) begin
            busy_out = 1'b1;
            if (sb.size() == 0) begin
              tot_cnt++;
              $display("FAIL unexpected_out: result %0h with empty scoreboard", result);
              cur = '{res: result, err: err, lat: 0};
            end else begin
              cur = sb.pop_front();
              chk("latency", cyc - acc_cyc, cur.lat);
              chk("result", result, cur.res);
              chk("err", err, cur.err);
            end
          end else begin
            chk("result_hold", result, cur.res);
            chk("err_hold", err, cur.err);
          end
          if (out_ready) busy_out = 1'b0;
        end
      end
    end
  end

  // Present one request for a single cycle, then scramble the inputs.
  task automatic send(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] cv, input logic [7:0] er, input logic ee, input int lat);
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = av; b = bv; c = cv;
    sb.push_back('{res: er, err: ee, lat: lat});
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
  endtask

  // Wait for the result, optionally stall the consumer, then complete the handshake.
  task automatic finish_op(input int hold);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      tot_cnt++;
      $display("FAIL out_valid_timeout: out_valid %0b after %0d cycles, want 1", out_valid, n);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("in_ready_stall", in_ready, 1'b0);
      chk("out_valid_stall", out_valid, 1'b1);
    end
    if (!out_ready) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    edone = (edone + 1) % 256;
    @(negedge clk);
    chk("done_count", done_count, edone);
    chk("in_ready_after", in_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0; c = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_done_count", done_count, 8'd0);
    chk("rst_result", result, 8'd0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;

    // Basic ops with hand-computed results.
    send(3'd3, 8'hA5, 8'h0F, 8'h00, 8'hAA, 1'b0, 2); finish_op(0);
    send(3'd5, 8'hF0, 8'hCC, 8'hAA, 8'hE8, 1'b0, 3); finish_op(0);
    out_ready = 1'b0;
    send(3'd1, 8'h3C, 8'hF0, 8'h00, 8'h30, 1'b0, 1); finish_op(5);
    send(3'd7, 8'h12, 8'h34, 8'h56, 8'h00, 1'b1, 1); finish_op(0);
    send(3'd6, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1, 1); finish_op(0);
    send(3'd2, 8'h0F, 8'h30, 8'h00, 8'h3F, 1'b0, 1); finish_op(0);
    send(3'd4, 8'hC3, 8'h0F, 8'h00, 8'h33, 1'b0, 2); finish_op(0);
    send(3'd5, 8'h0F, 8'h33, 8'h55, 8'h17, 1'b0, 3); finish_op(0);

    // Reset while MAJ sits at step 1: the op is dropped.
    send(3'd5, 8'hF0, 8'hCC, 8'hAA, 8'hE8, 1'b0, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_done_count", done_count, 8'd0);
    #2 rst = 1'b0;
    edone = 0;
    send(3'd0, 8'h5A, 8'h00, 8'h00, 8'hA5, 1'b0, 1); finish_op(0);

    // in_valid held through EXEC with moving operands: one acceptance only.
    acc0 = accepts;
    @(posedge clk); #1;
    in_valid = 1'b1; op = 3'd4; a = 8'hFF; b = 8'h0F; c = 8'h00;
    sb.push_back('{res: 8'h0F, err: 1'b0, lat: 2});
    @(posedge clk); #1;
    op = 3'd1; a = 8'h00; b = 8'hF0;
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34;
    @(posedge clk); #1;
    in_valid = 1'b0;
    finish_op(0);
    chk("single_accept", accepts - acc0, 1);

    // Run past 255 handshakes to exercise the counter wrap.
    for (int i = 0; i < 256; i++) begin
      send(3'd0, 8'(i), 8'h00, 8'h00, ~8'(i), 1'b0, 1);
      finish_op(0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/mux_gate_sequencer.md
MUX_GATE_SEQUENCER -- requirements
Module: mux_gate_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, lane count of operands, scratch registers and result.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  3  operation code; 0 NOT_A, 1 AND, 2 OR, 3 XOR, 4 XNOR, 5 MAJ; 6 and 7 illegal.
REQ-007 a, b, c  input  WIDTH each  operands; c is used by MAJ only.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 result  output  WIDTH  computed value.
REQ-011 err  output  1  set with out_valid when the op was illegal.
REQ-012 done_count  output  8  count of completed output handshakes.

Function
REQ-013 All logic evaluation SHALL use one shared WIDTH-bit 2:1 mux (y = sel ? d1 : d0 per lane), evaluated once per EXEC cycle; no other gates SHALL form the result.
REQ-014 Micro-op sources: sel from {a, b, c, t0, t1}; d0 and d1 from {all-0, all-1, a, b, c, t0, t1}; destination t0 or t1, both WIDTH-bit scratch registers.
REQ-015 Programs (step order): NOT_A: t0=mux(1,0,a). AND: t0=mux(0,b,a). OR: t0=mux(b,1,a). XOR: t0=mux(1,0,b); t0=mux(b,t0,a). XNOR: t0=mux(1,0,b); t0=mux(t0,b,a). MAJ: t0=mux(0,b,a); t1=mux(b,1,a); t0=mux(t0,t1,c).
REQ-016 Illegal op: one EXEC cycle with no mux write; result all-0, err 1.
REQ-017 FSM states IDLE, EXEC, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-018 IDLE: on in_valid && in_ready, latch op, a, b, c; clear step to 0; go to EXEC.
REQ-019 EXEC: execute the micro-op at step; increment step; after the last step of the program, go to DONE with result = t0.
REQ-020 Latency: out_valid rises exactly k rising edges after the accepting edge, where k = 1, 1, 1, 2, 2, 3 for ops 0..5 and 1 for illegal.
REQ-021 DONE: result and err held stable until out_valid && out_ready; on that edge go to IDLE and increment done_count (wraps 255 -> 0).
REQ-022 No bypass: a new request is never accepted on the same edge as an output handshake; minimum spacing is k+2 cycles.
REQ-023 in_valid, op, a, b and c are ignored outside IDLE; changes to them during EXEC or DONE do not affect result.

Reset
REQ-024 rst asserted: state IDLE, step 0, t0 and t1 0, result 0, err 0, done_count 0; therefore in_ready 1 and out_valid 0.
REQ-025 Reset during EXEC or DONE aborts the operation; no result is delivered and done_count is not incremented.

Structure
REQ-026 Package mux_gate_seq_pkg SHALL hold: op enum, source-select enum, destination enum, micro-op struct {sel_src, d0_src, d1_src, dst, last}, and constant MAX_STEPS = 3.
REQ-027 The program table SHALL be a combinational function of (op, step) returning a micro-op struct.
REQ-028 Sub-module: the existing 1-bit module mux, instantiated WIDTH times in a generate loop as the shared datapath.

Verification (WIDTH = 8)
REQ-029 XOR, a=8'hA5, b=8'h0F -> out_valid 2 cycles after accept, result 8'hAA, err 0.
REQ-030 MAJ, a=8'hF0, b=8'hCC, c=8'hAA -> out_valid 3 cycles after accept, result 8'hE8.
REQ-031 AND, a=8'h3C, b=8'hF0, out_ready low 5 cycles -> result 8'h30 stable, in_ready 0 throughout; after the handshake, done_count = 1.
REQ-032 op=3'd7 -> out_valid after 1 cycle, result 8'h00, err 1.
REQ-033 rst pulse during MAJ step 1 -> out_valid 0, in_ready 1, done_count 0; then NOT_A with a=8'h5A -> result 8'hA5.
REQ-034 in_valid held high with changing a, b during EXEC of XNOR (a=8'hFF, b=8'h0F) -> single acceptance only, result 8'h0F.
